// File: rtl/n64_joybus_pkg.sv
// Joybus sequencer shared types: FSM state encoding and controller command codes.
// Purely declarative; no latency and no flow control.
package n64_joybus_pkg;

    typedef enum logic [1:0] {
        ST_RX         = 2'd0,
        ST_TURNAROUND = 2'd1,
        ST_TX         = 2'd2,
        ST_RECOVER    = 2'd3
    } state_t;

    localparam logic [7:0] CMD_INFO     = 8'h00;
    localparam logic [7:0] CMD_INFO_ALT = 8'hFF;
    localparam logic [7:0] CMD_STATUS   = 8'h01;
    localparam logic [7:0] CMD_READ     = 8'h02;
    localparam logic [7:0] CMD_WRITE    = 8'h03;

    function automatic logic is_valid_cmd(input logic [7:0] c);
        return (c == CMD_INFO) || (c == CMD_INFO_ALT) || (c == CMD_STATUS) ||
               (c == CMD_READ) || (c == CMD_WRITE);
    endfunction

endpackage

// File: rtl/toggle_edge_detect.sv
// Flags any change of a toggle-handshake input against its value one cycle earlier.
// Change output is combinational from the registered copy; no backpressure.
module toggle_edge_detect (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic tog_i,
    output logic change_o
);

    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= tog_i;
        end
    end

    assign change_o = tog_i ^ prev_q;

endmodule

// File: rtl/n64_joybus_sequencer.sv
// Rx/Tx turnaround sequencer for a Joybus controller port: latches the command, waits, enables Tx.
// Tx starts TURNAROUND_CYCLES after acceptance; a stuck transmitter is cut off after TIMEOUT_CYCLES.
module n64_joybus_sequencer
    import n64_joybus_pkg::*;
#(
    parameter int TURNAROUND_CYCLES = 16,
    parameter int TIMEOUT_CYCLES    = 4096
) (
    input  logic        sample_clk,
    input  logic        reset_n,
    input  logic        rx_handoff,
    input  logic [7:0]  rx_cmd,
    input  logic [7:0]  rx_crc,
    input  logic        rx_error,
    input  logic        tx_handoff,
    input  logic [15:0] buttons_in,
    output logic        cur_operation,
    output logic [7:0]  cmd,
    output logic [7:0]  crc,
    output logic [15:0] button_state,
    output logic        timeout_pulse,
    output logic [7:0]  reject_count,
    output logic [15:0] tx_count
);

    localparam logic [7:0]  TA_LAST = 8'(TURNAROUND_CYCLES - 1);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic rx_evt;
    logic tx_evt;

    toggle_edge_detect u_rx_edge (
        .clk_i    (sample_clk),
        .rst_n_i  (reset_n),
        .tog_i    (rx_handoff),
        .change_o (rx_evt)
    );

    toggle_edge_detect u_tx_edge (
        .clk_i    (sample_clk),
        .rst_n_i  (reset_n),
        .tog_i    (tx_handoff),
        .change_o (tx_evt)
    );

    state_t      state_q, state_d;
    logic        cur_op_q, cur_op_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [7:0]  crc_q, crc_d;
    logic [15:0] btn_q, btn_d;
    logic        tmo_q, tmo_d;
    logic [7:0]  rej_q, rej_d;
    logic [15:0] txc_q, txc_d;
    logic [7:0]  ta_cnt_q, ta_cnt_d;
    logic [15:0] to_cnt_q, to_cnt_d;

    always_ff @(posedge sample_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_RX;
            cur_op_q <= 1'b0;
            cmd_q    <= 8'h00;
            crc_q    <= 8'h00;
            btn_q    <= 16'h0000;
            tmo_q    <= 1'b0;
            rej_q    <= 8'h00;
            txc_q    <= 16'h0000;
            ta_cnt_q <= 8'h00;
            to_cnt_q <= 16'h0000;
        end else begin
            state_q  <= state_d;
            cur_op_q <= cur_op_d;
            cmd_q    <= cmd_d;
            crc_q    <= crc_d;
            btn_q    <= btn_d;
            tmo_q    <= tmo_d;
            rej_q    <= rej_d;
            txc_q    <= txc_d;
            ta_cnt_q <= ta_cnt_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cur_op_d = cur_op_q;
        cmd_d    = cmd_q;
        crc_d    = crc_q;
        btn_d    = btn_q;
        tmo_d    = 1'b0;
        rej_d    = rej_q;
        txc_d    = txc_q;
        ta_cnt_d = ta_cnt_q;
        to_cnt_d = to_cnt_q;

        case (state_q)
            ST_RX: begin
                if (rx_evt) begin
                    if (!rx_error && is_valid_cmd(rx_cmd)) begin
                        cmd_d    = rx_cmd;
                        crc_d    = rx_crc;
                        btn_d    = buttons_in;
                        ta_cnt_d = 8'h00;
                        state_d  = ST_TURNAROUND;
                    end else if (rej_q != 8'hFF) begin
                        rej_d = rej_q + 8'd1;
                    end
                end
            end
            ST_TURNAROUND: begin
                if (ta_cnt_q == TA_LAST) begin
                    cur_op_d = 1'b1;
                    to_cnt_d = 16'h0000;
                    state_d  = ST_TX;
                end else begin
                    ta_cnt_d = ta_cnt_q + 8'd1;
                end
            end
            ST_TX: begin
                // Completion wins over a timeout landing in the same cycle.
                if (tx_evt) begin
                    cur_op_d = 1'b0;
                    txc_d    = txc_q + 16'd1;
                    state_d  = ST_RX;
                end else if (to_cnt_q == TO_LAST) begin
                    cur_op_d = 1'b0;
                    tmo_d    = 1'b1;
                    ta_cnt_d = 8'h00;
                    state_d  = ST_RECOVER;
                end else begin
                    to_cnt_d = to_cnt_q + 16'd1;
                end
            end
            ST_RECOVER: begin
                if (ta_cnt_q == TA_LAST) begin
                    state_d = ST_RX;
                end else begin
                    ta_cnt_d = ta_cnt_q + 8'd1;
                end
            end
            default: state_d = ST_RX;
        endcase
    end

    assign cur_operation = cur_op_q;
    assign cmd           = cmd_q;
    assign crc           = crc_q;
    assign button_state  = btn_q;
    assign timeout_pulse = tmo_q;
    assign reject_count  = rej_q;
    assign tx_count      = txc_q;

endmodule

// File: tb/tb_n64_joybus_sequencer.sv
// Directed bench for n64_joybus_sequencer: frame table plus hand-timed turnaround/timeout/reset sequences.
module tb_n64_joybus_sequencer;

    logic        sample_clk;
    logic        reset_n;
    logic        rx_handoff;
    logic [7:0]  rx_cmd;
    logic [7:0]  rx_crc;
    logic        rx_error;
    logic        tx_handoff;
    logic [15:0] buttons_in;
    logic        cur_operation;
    logic [7:0]  cmd;
    logic [7:0]  crc;
    logic [15:0] button_state;
    logic        timeout_pulse;
    logic [7:0]  reject_count;
    logic [15:0] tx_count;

    n64_joybus_sequencer #(
        .TURNAROUND_CYCLES (16),
        .TIMEOUT_CYCLES    (32)
    ) dut (
        .sample_clk    (sample_clk),
        .reset_n       (reset_n),
        .rx_handoff    (rx_handoff),
        .rx_cmd        (rx_cmd),
        .rx_crc        (rx_crc),
        .rx_error      (rx_error),
        .tx_handoff    (tx_handoff),
        .buttons_in    (buttons_in),
        .cur_operation (cur_operation),
        .cmd           (cmd),
        .crc           (crc),
        .button_state  (button_state),
        .timeout_pulse (timeout_pulse),
        .reject_count  (reject_count),
        .tx_count      (tx_count)
    );

    initial sample_clk = 1'b0;
    always #5 sample_clk = ~sample_clk;

    typedef struct {
        logic [7:0]  vcmd;
        logic [7:0]  vcrc;
        logic        verr;
        logic [15:0] vbtn;
        logic        acc;
    } vec_t;

    vec_t vt[9];

    int n_checks;
    int n_pass;

    logic        exp_cur;
    logic [7:0]  exp_cmd;
    logic [7:0]  exp_crc;
    logic [15:0] exp_btn;
    logic        exp_tmo;
    logic [7:0]  exp_rej;
    logic [15:0] exp_txc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":cur_operation"}, 32'(cur_operation), 32'(exp_cur));
        chk({tag, ":cmd"},           32'(cmd),           32'(exp_cmd));
        chk({tag, ":crc"},           32'(crc),           32'(exp_crc));
        chk({tag, ":button_state"},  32'(button_state),  32'(exp_btn));
        chk({tag, ":timeout_pulse"}, 32'(timeout_pulse), 32'(exp_tmo));
        chk({tag, ":reject_count"},  32'(reject_count),  32'(exp_rej));
        chk({tag, ":tx_count"},      32'(tx_count),      32'(exp_txc));
    endtask

    task automatic model_reset();
        exp_cur = 1'b0; exp_cmd = 8'h00; exp_crc = 8'h00; exp_btn = 16'h0000;
        exp_tmo = 1'b0; exp_rej = 8'h00; exp_txc = 16'h0000;
    endtask

    task automatic tick();
        @(posedge sample_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c, input logic [7:0] r, input logic e, input logic [15:0] b);
        rx_cmd     = c;
        rx_crc     = r;
        rx_error   = e;
        buttons_in = b;
        rx_handoff = ~rx_handoff;
        tick();
        rx_error   = 1'b0;
    endtask

    // Called right after the accepting edge; walks the turnaround with stray handoffs and input changes.
    task automatic go_tx();
        buttons_in = ~buttons_in;
        repeat (8) tick();
        rx_cmd     = 8'h01;
        rx_handoff = ~rx_handoff;
        tx_handoff = ~tx_handoff;
        repeat (7) tick();
        check_all("ta15");
        tick();
        exp_cur = 1'b1;
        check_all("ta16");
    endtask

    task automatic complete_tx();
        tx_handoff = ~tx_handoff;
        tick();
        exp_cur = 1'b0;
        exp_txc = exp_txc + 16'd1;
        check_all("tx_done");
        tx_handoff = ~tx_handoff;
        tick();
        check_all("tx_toggle_in_rx");
    endtask

    task automatic accept_expect(input logic [7:0] c, input logic [7:0] r, input logic [15:0] b);
        exp_cmd = c;
        exp_crc = r;
        exp_btn = b;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        vt[0] = '{8'h7E, 8'h00, 1'b0, 16'h0000, 1'b0};
        vt[1] = '{8'h00, 8'h5A, 1'b1, 16'h1234, 1'b0};
        vt[2] = '{8'h04, 8'h00, 1'b0, 16'h0000, 1'b0};
        vt[3] = '{8'h01, 8'h3C, 1'b0, 16'hA5C3, 1'b1};
        vt[4] = '{8'h00, 8'h81, 1'b0, 16'hFFFF, 1'b1};
        vt[5] = '{8'h02, 8'h42, 1'b0, 16'h0001, 1'b1};
        vt[6] = '{8'h03, 8'h99, 1'b0, 16'h8000, 1'b1};
        vt[7] = '{8'hFF, 8'hE7, 1'b0, 16'h5555, 1'b1};
        vt[8] = '{8'hFE, 8'h00, 1'b0, 16'h0000, 1'b0};

        reset_n = 1'b0; rx_handoff = 1'b0; tx_handoff = 1'b0; rx_cmd = 8'h00;
        rx_crc = 8'h00; rx_error = 1'b0; buttons_in = 16'h0000;
        model_reset();
        repeat (3) tick();
        check_all("reset");
        reset_n = 1'b1;
        tick();
        check_all("post_reset");

        rx_error = 1'b1;
        tick();
        rx_error = 1'b0;
        tick();
        check_all("err_only");

        for (int i = 0; i < 9; i++) begin
            send(vt[i].vcmd, vt[i].vcrc, vt[i].verr, vt[i].vbtn);
            if (vt[i].acc) accept_expect(vt[i].vcmd, vt[i].vcrc, vt[i].vbtn);
            else exp_rej = exp_rej + 8'd1;
            check_all($sformatf("row%0d", i));
            if (vt[i].acc) begin
                go_tx();
                complete_tx();
            end
        end

        // Timeout path with exact recover length.
        send(8'hFF, 8'h11, 1'b0, 16'h1111);
        accept_expect(8'hFF, 8'h11, 16'h1111);
        check_all("to_accept");
        go_tx();
        repeat (31) tick();
        check_all("to_31");
        tick();
        exp_cur = 1'b0;
        exp_tmo = 1'b1;
        check_all("to_fire");
        send(8'h02, 8'h22, 1'b0, 16'h2222);
        exp_tmo = 1'b0;
        check_all("rec_ignore1");
        repeat (14) tick();
        send(8'h02, 8'h22, 1'b0, 16'h2222);
        check_all("rec_ignore_last");
        send(8'h03, 8'h33, 1'b0, 16'h3333);
        accept_expect(8'h03, 8'h33, 16'h3333);
        check_all("rec_then_rx");
        go_tx();
        complete_tx();

        for (int i = 0; i < 300; i++) begin
            send(8'h7E, 8'h00, 1'b0, 16'h0000);
            if (exp_rej != 8'hFF) exp_rej = exp_rej + 8'd1;
        end
        check_all("saturate");

        send(8'h02, 8'h44, 1'b0, 16'h4444);
        accept_expect(8'h02, 8'h44, 16'h4444);
        check_all("pre_rst_accept");
        go_tx();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        rx_handoff = 1'b0;
        tx_handoff = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        check_all("after_rst");

        send(8'h01, 8'h55, 1'b0, 16'h5A5A);
        accept_expect(8'h01, 8'h55, 16'h5A5A);
        check_all("post_rst_accept");
        go_tx();
        complete_tx();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
